// File: rtl/i2c_cfg_target.sv
// rtl/i2c_cfg_target.sv - I2C register-access target (7-bit address, multi-byte pointer, auto-increment)
// bridging bus writes/reads onto single-cycle register-file strobes.
module i2c_cfg_target #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h74,
  parameter int         ADDR_BYTES  = 2,
  parameter int         DATA_WIDTH  = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                    clk_i,
  input  logic                    arstn_i,
  input  logic                    scl_pad_i,
  input  logic                    sda_pad_i,
  output logic                    sda_pad_o,
  output logic                    sda_padoen_o,
  output logic [8*ADDR_BYTES-1:0] reg_addr_o,
  output logic [DATA_WIDTH-1:0]   reg_wdata_o,
  output logic                    reg_we_o,
  output logic                    reg_re_o,
  input  logic [DATA_WIDTH-1:0]   reg_rdata_i,
  output logic                    busy_o
);
  localparam int AW = 8*ADDR_BYTES;
  localparam int DW = DATA_WIDTH;

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, ACK_DEV, REG_ADDR, ACK_REG, WR_DATA, ACK_WR, RD_DATA, RD_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_q, sda_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_pad_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_pad_i};
      scl_q    <= scl_sync[SYNC_STAGES-1];
      sda_q    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

  state_t          state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [DW-1:0]   rx_q, rx_d, tx_q, tx_d, wdata_q, wdata_d, rx_byte;
  logic [AW-1:0]   pshadow_q, pshadow_d, ptr_q, ptr_d, ptr_next;
  logic            we_q, we_d, re_q, re_d, oen_q, oen_d, busy_q, busy_d;
  logic            ack_phase_q, ack_phase_d, rd_q, rd_d;
  logic            byte_done;

  assign rx_byte   = {rx_q[DW-2:0], sda_s};
  assign byte_done = scl_rise && (bit_cnt_q == 4'(DW-1));
  // Pointer bytes collect in a shadow so an aborted pointer never disturbs the live one
  assign ptr_next  = AW'({pshadow_q, rx_byte});

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      wdata_q     <= '0;
      pshadow_q   <= '0;
      ptr_q       <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      oen_q       <= 1'b1;
      busy_q      <= 1'b0;
      ack_phase_q <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      wdata_q     <= wdata_d;
      pshadow_q   <= pshadow_d;
      ptr_q       <= ptr_d;
      we_q        <= we_d;
      re_q        <= re_d;
      oen_q       <= oen_d;
      busy_q      <= busy_d;
      ack_phase_q <= ack_phase_d;
      rd_q        <= rd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    rx_d        = rx_q;
    tx_d        = re_q ? reg_rdata_i : tx_q;
    wdata_d     = wdata_q;
    pshadow_d   = pshadow_q;
    ptr_d       = we_q ? ptr_q + AW'(1) : ptr_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    oen_d       = oen_q;
    busy_d      = busy_q;
    ack_phase_d = ack_phase_q;
    rd_d        = rd_q;

    if (scl_rise) begin
      rx_d      = rx_byte;
      bit_cnt_d = bit_cnt_q + 4'd1;
    end

    if (stop_det) begin
      state_d     = IDLE;
      oen_d       = 1'b1;
      busy_d      = 1'b0;
      ack_phase_d = 1'b0;
    end else if (start_det) begin
      state_d     = DEV_ADDR;
      oen_d       = 1'b1;
      busy_d      = 1'b1;
      bit_cnt_d   = '0;
      ack_phase_d = 1'b0;
    end else begin
      case (state_q)
        DEV_ADDR: if (byte_done) begin
          if (rx_byte[DW-1:1] == SLAVE_ADDR) begin
            state_d     = ACK_DEV;
            ack_phase_d = 1'b0;
            rd_d        = rx_byte[0];
            re_d        = rx_byte[0];
            byte_cnt_d  = '0;
          end else begin
            state_d = IGNORE;
          end
        end
        REG_ADDR: if (byte_done) begin
          pshadow_d   = ptr_next;
          byte_cnt_d  = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'(ADDR_BYTES-1)) ptr_d = ptr_next;
          state_d     = ACK_REG;
          ack_phase_d = 1'b0;
        end
        WR_DATA: if (byte_done) begin
          wdata_d     = rx_byte;
          we_d        = 1'b1;
          state_d     = ACK_WR;
          ack_phase_d = 1'b0;
        end
        // First SCL fall after the byte pulls SDA low; the next one ends the ACK slot
        ACK_DEV, ACK_REG, ACK_WR: if (scl_fall) begin
          if (!ack_phase_q) begin
            oen_d       = 1'b0;
            ack_phase_d = 1'b1;
          end else begin
            ack_phase_d = 1'b0;
            bit_cnt_d   = '0;
            oen_d       = 1'b1;
            case (state_q)
              ACK_DEV: if (rd_q) begin
                state_d = RD_DATA;
                oen_d   = tx_q[DW-1];
                tx_d    = tx_q << 1;
              end else begin
                state_d = REG_ADDR;
              end
              ACK_REG: state_d = (byte_cnt_q == 2'(ADDR_BYTES)) ? WR_DATA : REG_ADDR;
              default: state_d = WR_DATA;
            endcase
          end
        end
        RD_DATA: if (scl_fall) begin
          if (bit_cnt_q == 4'(DW)) begin
            oen_d       = 1'b1;
            state_d     = RD_ACK;
            ack_phase_d = 1'b0;
          end else begin
            oen_d = tx_q[DW-1];
            tx_d  = tx_q << 1;
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            ptr_d = ptr_q + AW'(1);
            if (!sda_s) begin
              re_d        = 1'b1;
              ack_phase_d = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end else if (scl_fall && ack_phase_q) begin
            state_d     = RD_DATA;
            ack_phase_d = 1'b0;
            bit_cnt_d   = '0;
            oen_d       = tx_q[DW-1];
            tx_d        = tx_q << 1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = oen_q;
  assign reg_addr_o   = ptr_q;
  assign reg_wdata_o  = wdata_q;
  assign reg_we_o     = we_q;
  assign reg_re_o     = re_q;
  assign busy_o       = busy_q;
endmodule

// File: tb/tb_i2c_cfg_target.sv
// tb/tb_i2c_cfg_target.sv - directed plus randomized I2C master stimulus for i2c_cfg_target,
// checked against a transaction-level pointer/strobe model.
module tb_i2c_cfg_target;
  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_pad_o, sda_padoen_o, reg_we, reg_re, busy;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata, reg_rdata;
  wire         sda_line = sda_m & (sda_padoen_o | sda_pad_o);

  logic [7:0]  rd_mem [0:65535];
  assign reg_rdata = rd_mem[reg_addr];

  always #5 clk = ~clk;

  i2c_cfg_target #(
    .SLAVE_ADDR (7'h74),
    .ADDR_BYTES (2),
    .DATA_WIDTH (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i       (clk),
    .arstn_i     (arstn),
    .scl_pad_i   (scl_m),
    .sda_pad_i   (sda_line),
    .sda_pad_o   (sda_pad_o),
    .sda_padoen_o(sda_padoen_o),
    .reg_addr_o  (reg_addr),
    .reg_wdata_o (reg_wdata),
    .reg_we_o    (reg_we),
    .reg_re_o    (reg_re),
    .reg_rdata_i (reg_rdata),
    .busy_o      (busy)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          both_cnt = 0;
  int          drive_cnt = 0;
  logic [23:0] obs_we[$], exp_we[$];
  logic [15:0] obs_re[$], exp_re[$];
  logic [15:0] m_ptr;
  logic [7:0]  wbuf [0:3];

  always @(negedge clk) begin
    if (reg_we) obs_we.push_back({reg_addr, reg_wdata});
    if (reg_re) obs_re.push_back(reg_addr);
    if (reg_we && reg_re) both_cnt++;
    if (!sda_padoen_o) drive_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic qtr();
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    sda_m = b; qtr();
    scl_m = 1'b1; qtr();
    r = sda_line; qtr();
    scl_m = 1'b0; qtr();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qtr();
    scl_m = 1'b1; qtr();
    sda_m = 1'b0; qtr();
    scl_m = 1'b0; qtr();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qtr();
    scl_m = 1'b1; qtr();
    sda_m = 1'b1; qtr();
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    logic r;
    for (int i = 7; i >= 0; i--) xfer_bit(b[i], r);
    xfer_bit(1'b1, r);
    chk(tag, 32'(r), 32'(exp_ack));
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] v);
    logic r;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      xfer_bit(1'b1, r);
      v = {v[6:0], r};
    end
    xfer_bit(nack, r);
  endtask

  task automatic check_strobes(input string tag);
    chk({tag, "_we_cnt"}, 32'(obs_we.size()), 32'(exp_we.size()));
    chk({tag, "_re_cnt"}, 32'(obs_re.size()), 32'(exp_re.size()));
    for (int i = 0; i < exp_we.size() && i < obs_we.size(); i++)
      chk($sformatf("%s_we%0d", tag, i), 32'(obs_we[i]), 32'(exp_we[i]));
    for (int i = 0; i < exp_re.size() && i < obs_re.size(); i++)
      chk($sformatf("%s_re%0d", tag, i), 32'(obs_re[i]), 32'(exp_re[i]));
    obs_we.delete(); exp_we.delete();
    obs_re.delete(); exp_re.delete();
  endtask

  task automatic write_txn(input logic [15:0] ptr, input int n, input string tag);
    i2c_start();
    chk({tag, "_busy1"}, 32'(busy), 32'h1);
    wr_byte(8'hE8, 1'b0, {tag, "_ack_dev"});
    wr_byte(ptr[15:8], 1'b0, {tag, "_ack_p1"});
    wr_byte(ptr[7:0], 1'b0, {tag, "_ack_p0"});
    m_ptr = ptr;
    for (int i = 0; i < n; i++) begin
      wr_byte(wbuf[i], 1'b0, {tag, "_ack_d"});
      exp_we.push_back({m_ptr, wbuf[i]});
      m_ptr++;
    end
    i2c_stop();
    chk({tag, "_busy0"}, 32'(busy), 32'h0);
    check_strobes(tag);
  endtask

  task automatic read_txn(input logic set_ptr, input logic [15:0] ptr, input int n, input string tag);
    logic [7:0] v, ev;
    if (set_ptr) begin
      i2c_start();
      wr_byte(8'hE8, 1'b0, {tag, "_ack_dev"});
      wr_byte(ptr[15:8], 1'b0, {tag, "_ack_p1"});
      wr_byte(ptr[7:0], 1'b0, {tag, "_ack_p0"});
      m_ptr = ptr;
    end
    i2c_start();
    wr_byte(8'hE9, 1'b0, {tag, "_ack_rd"});
    for (int i = 0; i < n; i++) begin
      exp_re.push_back(m_ptr);
      ev = rd_mem[m_ptr];
      rd_byte(i == n - 1, v);
      chk($sformatf("%s_data%0d", tag, i), 32'(v), 32'(ev));
      m_ptr++;
    end
    chk({tag, "_released"}, 32'(sda_padoen_o), 32'h1);
    i2c_stop();
    check_strobes(tag);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) rd_mem[i] = 8'($urandom);
    rd_mem[16'h0B24] = 8'hA5;
    rd_mem[16'h0B25] = 8'h5A;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_oen", 32'(sda_padoen_o), 32'h1);
    chk("rst_pad", 32'(sda_pad_o), 32'h0);
    chk("rst_we", 32'(reg_we), 32'h0);
    chk("rst_re", 32'(reg_re), 32'h0);
    chk("rst_addr", 32'(reg_addr), 32'h0);
    chk("rst_wdata", 32'(reg_wdata), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    arstn = 1'b1;
    qtr();
    m_ptr = 16'h0000;

    wbuf[0] = 8'hC0;
    write_txn(16'h0B24, 1, "wr1");
    chk("wr1_ptr", 32'(reg_addr), 32'h0B25);

    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    write_txn(16'h0B24, 3, "burst");

    read_txn(1'b1, 16'h0B24, 2, "comb");

    drive_cnt = 0;
    i2c_start();
    wr_byte(8'hEA, 1'b1, "badaddr_nak");
    wr_byte(8'h00, 1'b1, "badaddr_b1");
    wr_byte(8'h11, 1'b1, "badaddr_b2");
    i2c_stop();
    chk("badaddr_drive", 32'(drive_cnt), 32'h0);
    chk("badaddr_busy", 32'(busy), 32'h0);
    chk("badaddr_ptr", 32'(reg_addr), 32'(m_ptr));
    check_strobes("badaddr");

    wbuf[0] = 8'h01; wbuf[1] = 8'h02;
    write_txn(16'hFFFF, 2, "wrap");

    begin
      logic r;
      i2c_start();
      wr_byte(8'hE8, 1'b0, "abort_ack_dev");
      wr_byte(8'h00, 1'b0, "abort_ack_p1");
      wr_byte(8'h10, 1'b0, "abort_ack_p0");
      m_ptr = 16'h0010;
      xfer_bit(1'b1, r); xfer_bit(1'b0, r); xfer_bit(1'b1, r); xfer_bit(1'b1, r);
      i2c_stop();
      check_strobes("abort");
      chk("abort_ptr", 32'(reg_addr), 32'h0010);
    end

    i2c_start();
    wr_byte(8'hE8, 1'b0, "part_ack_dev");
    wr_byte(8'h12, 1'b0, "part_ack_p1");
    i2c_stop();
    chk("part_ptr", 32'(reg_addr), 32'(m_ptr));
    read_txn(1'b0, 16'h0000, 1, "oldptr");

    rd_mem[m_ptr] = 8'h00;
    i2c_start();
    wr_byte(8'hE9, 1'b0, "rst_rd_ack");
    exp_re.push_back(m_ptr);
    sda_m = 1'b1; qtr();
    scl_m = 1'b1; qtr();
    chk("rst_rd_drive", 32'(sda_padoen_o), 32'h0);
    arstn = 1'b0;
    #1;
    chk("rstmid_oen", 32'(sda_padoen_o), 32'h1);
    chk("rstmid_line", 32'(sda_line), 32'h1);
    chk("rstmid_we", 32'(reg_we), 32'h0);
    chk("rstmid_re", 32'(reg_re), 32'h0);
    chk("rstmid_addr", 32'(reg_addr), 32'h0);
    chk("rstmid_wdata", 32'(reg_wdata), 32'h0);
    chk("rstmid_busy", 32'(busy), 32'h0);
    check_strobes("rstmid");
    qtr();
    arstn = 1'b1;
    qtr();
    m_ptr = 16'h0000;

    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        int n;
        n = int'($urandom_range(1, 3));
        for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
        write_txn(16'($urandom), n, "rnd_wr");
      end else begin
        read_txn(1'($urandom_range(0, 1)), 16'($urandom), int'($urandom_range(1, 3)), "rnd_rd");
      end
    end

    chk("we_re_overlap", 32'(both_cnt), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
